// File: rtl/instruction_fetch_pkg.sv
// Shared types for the instruction fetch path.
//   memory_op_e   : operation codes driven onto the memory op interface
//   fetch_state_e : fetch FSM states
//   PC_STEP       : amount added to the memory PC after each fetched word
package instruction_fetch_pkg;

  localparam int ADDR_BUS_WIDTH = 8;

  typedef enum logic [2:0] {
    NOP      = 3'd0,
    READ     = 3'd1,
    WRITE    = 3'd2,
    REL_ADD  = 3'd3,
    REL_SUB  = 3'd4,
    ABSOLUTE = 3'd5
  } memory_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HI  = 3'd1,
    RD_LO  = 3'd2,
    RD_END = 3'd3,
    INC    = 3'd4,
    HOLD   = 3'd5,
    JUMP   = 3'd6
  } fetch_state_e;

  localparam logic [7:0] PC_STEP = 8'd1;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: initiator on the memory op interface. Pulls 16-bit words
// through the memory PC path (two byte reads, then PC += 1), hands each word
// to the control sequencer over valid/ready, and loads the PC on jumps.
// Ports:
//   i_clock, i_reset_n        : clock, async active-low reset
//   i_fetch_en                : keep fetching while high
//   o_instr_valid/i_instr_ready/o_instr : word handshake to sequencer
//   i_jump_req/i_jump_target/o_jump_ack : absolute jump request
//   o_mem_op, o_mem_bus_sel, o_mem_word_sel, o_mem_wdata, i_mem_rdata : memory
//   o_busy                    : FSM not in IDLE
//
// state  | meaning
// IDLE   | no memory traffic, waiting for fetch_en
// RD_HI  | READ addressing the high byte (primes memory output register)
// RD_LO  | READ low byte, high byte visible on rdata and captured
// RD_END | READ low byte again, low byte visible on rdata and captured
// INC    | REL_ADD by PC_STEP, word becomes valid at end of cycle
// HOLD   | word presented, waiting for valid&ready
// JUMP   | ABSOLUTE with jump_target, jump_ack pulsed
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int   ADDR_W      = ADDR_BUS_WIDTH,
  parameter logic HI_BYTE_SEL = 1'b0
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_fetch_en,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [15:0] o_instr,
  input  logic        i_jump_req,
  input  logic [7:0]  i_jump_target,
  output logic        o_jump_ack,
  output memory_op_e  o_mem_op,
  output logic        o_mem_bus_sel,
  output logic        o_mem_word_sel,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_busy
);

  // ADDR_W only documents the memory PC width; the PC itself lives in memory.
  if (ADDR_W < 1) begin : g_addr_w_invalid
  end

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  memory_op_e   r_mem_op;
  memory_op_e   w_mem_op;
  logic         r_word_sel;
  logic         w_word_sel;
  logic [7:0]   r_wdata;
  logic [7:0]   w_wdata;
  logic         r_jump_ack;
  logic         w_jump_ack;
  logic         r_instr_valid;
  logic         r_busy;
  logic [15:0]  r_instr;
  logic         w_handshake;

  assign w_handshake = r_instr_valid & i_instr_ready;

  // Jump wins from every state except JUMP itself; in HOLD a simultaneous
  // handshake still consumes the word because valid drops on the same edge.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    w_next_state = i_jump_req ? JUMP : (i_fetch_en ? RD_HI : IDLE);
      RD_HI:   w_next_state = i_jump_req ? JUMP : RD_LO;
      RD_LO:   w_next_state = i_jump_req ? JUMP : RD_END;
      RD_END:  w_next_state = i_jump_req ? JUMP : INC;
      INC:     w_next_state = i_jump_req ? JUMP : HOLD;
      HOLD: begin
        if (i_jump_req)       w_next_state = JUMP;
        else if (w_handshake) w_next_state = i_fetch_en ? RD_HI : IDLE;
        else                  w_next_state = HOLD;
      end
      JUMP:    w_next_state = i_fetch_en ? RD_HI : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each state's
  // memory op is on the bus for exactly the cycle the FSM sits in it.
  always_comb begin
    w_mem_op   = NOP;
    w_word_sel = 1'b0;
    w_wdata    = 8'd0;
    w_jump_ack = 1'b0;
    unique case (w_next_state)
      RD_HI: begin
        w_mem_op   = READ;
        w_word_sel = HI_BYTE_SEL;
      end
      RD_LO, RD_END: begin
        w_mem_op   = READ;
        w_word_sel = ~HI_BYTE_SEL;
      end
      INC: begin
        w_mem_op = REL_ADD;
        w_wdata  = PC_STEP;
      end
      JUMP: begin
        w_mem_op   = ABSOLUTE;
        w_wdata    = i_jump_target;
        w_jump_ack = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_mem_op      <= NOP;
      r_word_sel    <= 1'b0;
      r_wdata       <= 8'd0;
      r_jump_ack    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_mem_op      <= w_mem_op;
      r_word_sel    <= w_word_sel;
      r_wdata       <= w_wdata;
      r_jump_ack    <= w_jump_ack;
      // HOLD is only entered from INC, so valid tracks the state exactly.
      r_instr_valid <= (w_next_state == HOLD);
      r_busy        <= (w_next_state != IDLE);
    end
  end

  // Memory output lags one READ cycle: the high byte shows up during RD_LO,
  // the low byte during RD_END.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_instr <= 16'd0;
    end else begin
      if (r_state == RD_LO)  r_instr[15:8] <= i_mem_rdata;
      if (r_state == RD_END) r_instr[7:0]  <= i_mem_rdata;
    end
  end

  assign o_instr_valid  = r_instr_valid;
  assign o_instr        = r_instr;
  assign o_jump_ack     = r_jump_ack;
  assign o_mem_op       = r_mem_op;
  assign o_mem_bus_sel  = 1'b1;
  assign o_mem_word_sel = r_word_sel;
  assign o_mem_wdata    = r_wdata;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural memory on the PC path.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        jump_req;
  logic [7:0]  jump_target;
  logic        jump_ack;
  memory_op_e  mem_op;
  logic        mem_bus_sel;
  logic        mem_word_sel;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(8), .HI_BYTE_SEL(1'b0)) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_fetch_en     (fetch_en),
    .o_instr_valid  (instr_valid),
    .i_instr_ready  (instr_ready),
    .o_instr        (instr),
    .i_jump_req     (jump_req),
    .i_jump_target  (jump_target),
    .o_jump_ack     (jump_ack),
    .o_mem_op       (mem_op),
    .o_mem_bus_sel  (mem_bus_sel),
    .o_mem_word_sel (mem_word_sel),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata),
    .o_busy         (busy)
  );

  // Memory model: word_sel 0 selects the high byte, PC wraps at 8 bits.
  logic [15:0] mem [256];
  logic [7:0]  pc;
  logic [7:0]  out_tmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= 8'd0;
      out_tmp <= 8'd0;
    end else begin
      case (mem_op)
        READ:     out_tmp <= mem_word_sel ? mem[pc][7:0] : mem[pc][15:8];
        REL_ADD:  pc <= pc + mem_wdata;
        ABSOLUTE: pc <= mem_wdata;
        default:  ;
      endcase
    end
  end

  assign mem_rdata = (mem_op == READ) ? out_tmp : 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"},   {16'd0, instr}, 32'd0);
    check({tag, "_op"},      {29'd0, mem_op}, {29'd0, NOP});
    check({tag, "_ack"},     {31'd0, jump_ack}, 32'd0);
    check({tag, "_wdata"},   {24'd0, mem_wdata}, 32'd0);
    check({tag, "_wsel"},    {31'd0, mem_word_sel}, 32'd0);
    check({tag, "_bussel"},  {31'd0, mem_bus_sel}, 32'd1);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    instr_ready = 1'b0;
    jump_req    = 1'b0;
    jump_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257 + 16'h0101);
    mem[8'h00] = 16'hA53C;
    mem[8'h01] = 16'h1234;
    mem[8'h20] = 16'hBEEF;
    mem[8'hFF] = 16'hC0DE;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");

    // First word after reset release
    fetch_en = 1'b1;
    rst_n    = 1'b1;
    tick();
    check("rdhi_op",   {29'd0, mem_op}, {29'd0, READ});
    check("rdhi_wsel", {31'd0, mem_word_sel}, 32'd0);
    check("rdhi_busy", {31'd0, busy}, 32'd1);
    tick();
    check("rdlo_wsel", {31'd0, mem_word_sel}, 32'd1);
    tick();
    check("rdend_op",  {29'd0, mem_op}, {29'd0, READ});
    tick();
    check("inc_op",    {29'd0, mem_op}, {29'd0, REL_ADD});
    check("inc_wdata", {24'd0, mem_wdata}, 32'd1);
    check("inc_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("w0_valid",  {31'd0, instr_valid}, 32'd1);
    check("w0_instr",  {16'd0, instr}, 32'hA53C);
    check("w0_pc",     {24'd0, pc}, 32'd1);

    // Sequencer stalls for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", {16'd0, instr}, 32'hA53C);
      check("stall_op",    {29'd0, mem_op}, {29'd0, NOP});
      check("stall_pc",    {24'd0, pc}, 32'd1);
    end

    // Handshake with fetch_en dropped: park in IDLE
    instr_ready = 1'b1;
    fetch_en    = 1'b0;
    tick();
    instr_ready = 1'b0;
    check("park_valid", {31'd0, instr_valid}, 32'd0);
    check("park_busy",  {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("park_op", {29'd0, mem_op}, {29'd0, NOP});
    end
    check("park_pc", {24'd0, pc}, 32'd1);

    // Jump raised during RD_LO aborts the partial word
    fetch_en    = 1'b1;
    jump_target = 8'h20;
    tick();
    tick();
    check("abort_rdlo_wsel", {31'd0, mem_word_sel}, 32'd1);
    jump_req = 1'b1;
    tick();
    check("jmp_ack",   {31'd0, jump_ack}, 32'd1);
    check("jmp_op",    {29'd0, mem_op}, {29'd0, ABSOLUTE});
    check("jmp_wdata", {24'd0, mem_wdata}, 32'h20);
    check("jmp_valid", {31'd0, instr_valid}, 32'd0);
    jump_req = 1'b0;
    tick();
    check("jmp_ack_pulse", {31'd0, jump_ack}, 32'd0);
    check("jmp_pc",        {24'd0, pc}, 32'h20);
    wait_valid(n);
    check("jmp_latency", n, 32'd4);
    check("jmp_instr",   {16'd0, instr}, 32'hBEEF);
    check("jmp_pc_inc",  {24'd0, pc}, 32'h21);

    // Handshake and jump together in HOLD, then fetch the last address
    instr_ready = 1'b1;
    jump_req    = 1'b1;
    jump_target = 8'hFF;
    tick();
    instr_ready = 1'b0;
    check("hj_ack",   {31'd0, jump_ack}, 32'd1);
    check("hj_valid", {31'd0, instr_valid}, 32'd0);
    check("hj_wdata", {24'd0, mem_wdata}, 32'hFF);
    jump_req = 1'b0;
    wait_valid(n);
    check("wrap_latency", n, 32'd5);
    check("wrap_instr",   {16'd0, instr}, 32'hC0DE);
    check("wrap_pc",      {24'd0, pc}, 32'd0);

    // Fetch word 0 again, then start word 1
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_valid(n);
    check("w0b_instr", {16'd0, instr}, 32'hA53C);
    check("w0b_pc",    {24'd0, pc}, 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_op", {29'd0, mem_op}, {29'd0, READ});

    // Reset pulse in RD_END: outputs clear without waiting for a clock
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_pc", {24'd0, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    check("restart_latency", n, 32'd5);
    check("restart_instr",   {16'd0, instr}, 32'hA53C);
    check("restart_pc",      {24'd0, pc}, 32'd1);

    // Steady state with ready high: one word every 5 cycles
    instr_ready = 1'b1;
    tick();
    check("tp_valid_drop", {31'd0, instr_valid}, 32'd0);
    wait_valid(n);
    check("tp_cycles", n, 32'd4);
    check("tp_instr",  {16'd0, instr}, 32'h1234);
    check("tp_pc",     {24'd0, pc}, 32'd2);
    instr_ready = 1'b0;
    fetch_en    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
